// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: one active-low column per ce1ms tick, debounced press/release,
// accepted keys shifted as nibbles into dat (newest digit in [3:0]).
module keypad_scanner #(
  parameter int DIGITS      = 4,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce1ms,
  input  logic                  clr,
  input  logic [3:0]            rows,
  output logic [3:0]            cols,
  output logic                  key_valid,
  output logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   dat
);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] RELEASE  = 2'd2;
  localparam logic [7:0] DB_LIM   = 8'(DEBOUNCE_MS);

  logic [1:0]          state;
  logic [1:0]          col;
  logic [3:0]          rows_m;
  logic [3:0]          rs;
  logic [3:0]          pat;
  logic [7:0]          cnt;
  logic [7:0]          cnt_nxt;
  logic                one_low;
  logic [1:0]          low_row;
  logic [4*DIGITS-1:0] dat_shift;

  assign cnt_nxt = cnt + 8'd1;
  assign cols    = ~(4'b0001 << col);

  // A ghost or multi-key pattern has more than one low row and is never accepted.
  always_comb begin
    one_low = 1'b1;
    low_row = 2'd0;
    case (pat)
      4'b1110: low_row = 2'd0;
      4'b1101: low_row = 2'd1;
      4'b1011: low_row = 2'd2;
      4'b0111: low_row = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    dat_shift      = dat << 4;
    dat_shift[3:0] = {low_row, col};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col       <= 2'd0;
      rows_m    <= 4'hF;
      rs        <= 4'hF;
      pat       <= 4'hF;
      cnt       <= 8'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      dat       <= '0;
    end else begin
      rows_m    <= rows;
      rs        <= rows_m;
      key_valid <= 1'b0;
      if (clr) dat <= '0;
      if (ce1ms) begin
        case (state)
          SCAN: begin
            if (rs == 4'hF) begin
              col <= col + 2'd1;
            end else begin
              pat   <= rs;
              cnt   <= 8'd0;
              state <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (rs != pat) begin
              state <= SCAN;
            end else if (cnt_nxt == DB_LIM) begin
              cnt   <= 8'd0;
              state <= RELEASE;
              if (one_low) begin
                key_valid <= 1'b1;
                key_code  <= {low_row, col};
                if (!clr) dat <= dat_shift;
              end
            end else begin
              cnt <= cnt_nxt;
            end
          end
          RELEASE: begin
            // Column stays on the held key, so only a full release restarts scanning.
            if (rs != 4'hF) begin
              cnt <= 8'd0;
            end else if (cnt_nxt == DB_LIM) begin
              cnt   <= 8'd0;
              state <= SCAN;
              col   <= col + 2'd1;
            end else begin
              cnt <= cnt_nxt;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with DEBOUNCE_MS=3: a keypad model drives rows from cols,
// directed vectors and hand-written sequences check scan, debounce, ghost, clr and reset.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst, ce1ms, clr;
  logic [3:0]  rows, cols, key_code;
  logic        key_valid;
  logic [15:0] dat;

  logic        force_mode;
  logic [3:0]  force_rows;
  logic        pressed;
  logic [3:0]  key;
  logic        kv_seen;
  logic        prev_kv = 1'b0;
  logic        b2b_seen = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          p0;

  typedef struct {
    logic [3:0]  key;
    logic [3:0]  exp_code;
    logic [15:0] exp_dat;
    int          exp_pulses;
  } vec_t;

  vec_t       seq_tbl[5];
  logic [3:0] scan_exp[4];

  always #5 clk = ~clk;

  keypad_scanner #(.DIGITS(4), .DEBOUNCE_MS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce1ms     (ce1ms),
    .clr       (clr),
    .rows      (rows),
    .cols      (cols),
    .key_valid (key_valid),
    .key_code  (key_code),
    .dat       (dat)
  );

  // Keypad model: a pressed key pulls its row low only while its column is driven.
  always_comb begin
    rows = 4'hF;
    if (force_mode) rows = force_rows;
    else if (pressed && !cols[key[1:0]]) rows[key[3:2]] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      pulses = pulses + 1;
      if (prev_kv) b2b_seen = 1'b1;
    end
    prev_kv = key_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic with_clr);
    repeat (6) @(negedge clk);
    ce1ms = 1'b1;
    clr   = with_clr;
    @(negedge clk);
    ce1ms   = 1'b0;
    clr     = 1'b0;
    kv_seen = key_valid;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic goto_col(input int c);
    logic [3:0] want;
    want = ~(4'b0001 << c);
    for (int i = 0; i < 8 && cols != want; i++) tick(1'b0);
    chk("goto_col", {28'd0, cols}, {28'd0, want});
  endtask

  task automatic press_release(input logic [3:0] k);
    force_mode = 1'b0;
    key        = k;
    pressed    = 1'b1;
    ticks(12);
    pressed = 1'b0;
    ticks(8);
  endtask

  initial begin
    rst = 1'b0; ce1ms = 1'b0; clr = 1'b0;
    force_mode = 1'b0; force_rows = 4'hF; pressed = 1'b0; key = 4'd0; kv_seen = 1'b0;

    scan_exp[0] = 4'b1101; scan_exp[1] = 4'b1011;
    scan_exp[2] = 4'b0111; scan_exp[3] = 4'b1110;
    seq_tbl[0] = '{4'h1, 4'h1, 16'h0001, 1};
    seq_tbl[1] = '{4'h2, 4'h2, 16'h0012, 2};
    seq_tbl[2] = '{4'h3, 4'h3, 16'h0123, 3};
    seq_tbl[3] = '{4'h4, 4'h4, 16'h1234, 4};
    seq_tbl[4] = '{4'h5, 4'h5, 16'h2345, 5};

    // Reset values and idle column rotation
    do_reset();
    chk("rst_cols", {28'd0, cols}, 32'hE);
    chk("rst_dat", {16'd0, dat}, 32'h0);
    chk("rst_kv", {31'd0, key_valid}, 32'h0);
    chk("rst_code", {28'd0, key_code}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      chk("scan_cols", {28'd0, cols}, {28'd0, scan_exp[i]});
    end

    // Exact acceptance latency: key 4 (row 1, col 0) found on first tick, accepted on fourth
    key = 4'h4; pressed = 1'b1;
    ticks(3);
    chk("lat_early", {31'd0, kv_seen}, 32'h0);
    tick(1'b0);
    chk("lat_kv", {31'd0, kv_seen}, 32'h1);
    chk("lat_code", {28'd0, key_code}, 32'h4);
    chk("lat_dat", {16'd0, dat}, 32'h0004);
    @(negedge clk);
    chk("kv_one_clk", {31'd0, key_valid}, 32'h0);
    pressed = 1'b0;
    ticks(8);

    // Clean press of A, then long hold without auto-repeat
    do_reset();
    p0 = pulses;
    key = 4'hA; pressed = 1'b1;
    ticks(12);
    chk("clean_pulses", pulses - p0, 1);
    chk("clean_code", {28'd0, key_code}, 32'hA);
    chk("clean_dat", {16'd0, dat}, 32'h000A);
    ticks(50);
    chk("hold_no_repeat", pulses - p0, 1);
    pressed = 1'b0;
    ticks(8);

    // Bounce on row 0 in column 1
    do_reset();
    tick(1'b0);
    chk("bounce_col1", {28'd0, cols}, 32'hD);
    p0 = pulses;
    force_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      force_rows = (i % 2 == 0) ? 4'b1110 : 4'hF;
      tick(1'b0);
    end
    chk("bounce_no_rotate", {28'd0, cols}, 32'hD);
    chk("bounce_no_pulse", pulses - p0, 0);
    force_mode = 1'b0;
    press_release(4'h1);
    chk("bounce_then_code", {28'd0, key_code}, 32'h1);
    chk("bounce_then_pulse", pulses - p0, 1);

    // Key sequence with overflow
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      press_release(seq_tbl[i].key);
      chk("seq_code", {28'd0, key_code}, {28'd0, seq_tbl[i].exp_code});
      chk("seq_dat", {16'd0, dat}, {16'd0, seq_tbl[i].exp_dat});
      chk("seq_pulses", pulses - p0, seq_tbl[i].exp_pulses);
    end

    // Ghost pattern in column 3
    goto_col(3);
    p0 = pulses;
    force_mode = 1'b1;
    force_rows = 4'b1010;
    ticks(10);
    chk("ghost_no_pulse", pulses - p0, 0);
    chk("ghost_dat", {16'd0, dat}, 32'h2345);
    chk("ghost_hold_col", {28'd0, cols}, 32'h7);
    force_rows = 4'hF;
    ticks(2);
    chk("ghost_release_wait", {28'd0, cols}, 32'h7);
    tick(1'b0);
    chk("ghost_release_done", {28'd0, cols}, 32'hE);
    force_mode = 1'b0;

    // clr coincident with acceptance of key F
    goto_col(3);
    key = 4'hF; pressed = 1'b1;
    ticks(3);
    chk("clr_early", {31'd0, kv_seen}, 32'h0);
    tick(1'b1);
    chk("clr_kv", {31'd0, kv_seen}, 32'h1);
    chk("clr_code", {28'd0, key_code}, 32'hF);
    chk("clr_dat", {16'd0, dat}, 32'h0);
    pressed = 1'b0;
    ticks(8);

    // Reset in the middle of DEBOUNCE discards the press
    goto_col(2);
    p0 = pulses;
    key = 4'h6; pressed = 1'b1;
    ticks(2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cols", {28'd0, cols}, 32'hE);
    chk("mid_rst_code", {28'd0, key_code}, 32'h0);
    chk("mid_rst_kv", {31'd0, key_valid}, 32'h0);
    chk("mid_rst_dat", {16'd0, dat}, 32'h0);
    ticks(3);
    chk("mid_rst_no_pulse", pulses - p0, 0);
    pressed = 1'b0;
    ticks(4);

    chk("kv_never_b2b", {31'd0, b2b_seen}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
